rsss_lock_ctrl: RTL and testbench

Sequencing controller for the serial-password lock. Accepts a 16-bit code over a valid/ready handshake and checks it bit-serially, MSB first, against a stored code. Drives the active-low lock output, counts consecutive failures and raises the buzzer with a timed lockout after too many. Sits between the keypad/entry front end and the lock actuator/buzzer drivers.

---
 rtl/rsss_pkg.sv | 16 +
 rtl/rsss_bit_cmp.sv | 43 ++++
 rtl/rsss_lock_ctrl.sv | 147 ++++++++++++++
 tb/tb_rsss_lock_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsss_pkg.sv
// Shared types and constants for the serial-password lock controller.
package rsss_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CHECK   = 2'd1,
    OPEN    = 2'd2,
    LOCKOUT = 2'd3
  } state_t;

  localparam logic [15:0] DEFAULT_CODE = 16'h1732;

  localparam logic LOCK_OPEN = 1'b0;
  localparam logic LOCK_SHUT = 1'b1;

endpackage

// File: rtl/rsss_bit_cmp.sv
// Bit-serial code comparator: shift register, bit counter and sticky mismatch flag.
// done is high on the cycle holding the last (LSB) compare; match covers that bit too.
module rsss_bit_cmp #(
  parameter int CODE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              step,
  input  logic [CODE_W-1:0] code_in,
  input  logic [CODE_W-1:0] ref_code,
  output logic              done,
  output logic              match
);

  localparam int CW = $clog2(CODE_W);

  logic [CODE_W-1:0] shreg;
  logic [CW-1:0]     bit_idx;
  logic              miss;
  logic              bit_miss;

  assign bit_miss = shreg[CODE_W-1] ^ ref_code[bit_idx];
  assign done     = (bit_idx == '0);
  assign match    = ~(miss | bit_miss);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shreg   <= '0;
      bit_idx <= '0;
      miss    <= 1'b0;
    end else if (load) begin
      shreg   <= code_in;
      bit_idx <= CW'(CODE_W - 1);
      miss    <= 1'b0;
    end else if (step) begin
      shreg   <= {shreg[CODE_W-2:0], 1'b0};
      bit_idx <= bit_idx - 1'b1;
      miss    <= miss | bit_miss;
    end
  end

endmodule

// File: rtl/rsss_lock_ctrl.sv
// Serial-password lock sequencer: code check, open/relock timing, failure lockout.
// Define LOCK_PROG_EN to add prog_valid/prog_code for reprogramming the code while open.
//
//   state   | meaning
//   IDLE    | ready for a code, lock shut
//   CHECK   | comparing entered code, one bit per cycle
//   OPEN    | lock driven open until timeout, relock or reprogram
//   LOCKOUT | buzzer on, codes ignored until the timer expires
module rsss_lock_ctrl #(
  parameter int                CODE_W       = 16,
  parameter logic [CODE_W-1:0] DEFAULT_CODE = 16'h1732,
  parameter int                MAX_FAIL     = 3,
  parameter int                LOCKOUT_CYC  = 64,
  parameter int                OPEN_CYC     = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          code_valid,
  output logic                          code_ready,
  input  logic [CODE_W-1:0]             code_in,
  input  logic                          relock,
  output logic                          out,
  output logic                          out_buzz,
  output logic [1:0]                    state,
  output logic [$clog2(MAX_FAIL+1)-1:0] fail_cnt
`ifdef LOCK_PROG_EN
  ,
  input  logic                          prog_valid,
  input  logic [CODE_W-1:0]             prog_code
`endif
);

  import rsss_pkg::*;

  localparam int FW = $clog2(MAX_FAIL + 1);
  localparam int TW = $clog2((LOCKOUT_CYC > OPEN_CYC) ? LOCKOUT_CYC : OPEN_CYC);

  state_t            st_q, st_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [FW-1:0]     fail_q, fail_d, fail_inc;
  logic              out_d, buzz_d;
  logic              load, step, done, match;
  logic              prog_hit;
  logic [CODE_W-1:0] ref_code;

`ifdef LOCK_PROG_EN
  logic [CODE_W-1:0] code_q;

  assign prog_hit = (st_q == OPEN) && prog_valid;
  assign ref_code = code_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)          code_q <= DEFAULT_CODE;
    else if (prog_hit) code_q <= prog_code;
  end
`else
  assign prog_hit = 1'b0;
  assign ref_code = DEFAULT_CODE;
`endif

  rsss_bit_cmp #(.CODE_W(CODE_W)) u_cmp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .code_in  (code_in),
    .ref_code (ref_code),
    .done     (done),
    .match    (match)
  );

  assign code_ready = (st_q == IDLE);
  assign state      = st_q;
  assign fail_cnt   = fail_q;

  always_comb begin
    st_d     = st_q;
    tmr_d    = tmr_q;
    fail_d   = fail_q;
    fail_inc = fail_q + 1'b1;
    load     = 1'b0;
    step     = 1'b0;
    case (st_q)
      IDLE: begin
        if (code_valid) begin
          load = 1'b1;
          st_d = CHECK;
        end
      end
      CHECK: begin
        step = 1'b1;
        if (done) begin
          if (match) begin
            st_d   = OPEN;
            fail_d = '0;
            tmr_d  = TW'(OPEN_CYC - 1);
          end else begin
            fail_d = fail_inc;
            if (fail_inc == FW'(MAX_FAIL)) begin
              st_d  = LOCKOUT;
              tmr_d = TW'(LOCKOUT_CYC - 1);
            end else begin
              st_d = IDLE;
            end
          end
        end
      end
      OPEN: begin
        // Timeout, relock and reprogram all collapse into one return to IDLE.
        if (tmr_q == '0 || relock || prog_hit) begin
          st_d  = IDLE;
          tmr_d = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      LOCKOUT: begin
        if (tmr_q == '0) begin
          st_d   = IDLE;
          fail_d = '0;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
    out_d  = (st_d == OPEN) ? LOCK_OPEN : LOCK_SHUT;
    buzz_d = (st_d == LOCKOUT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q     <= IDLE;
      tmr_q    <= '0;
      fail_q   <= '0;
      out      <= LOCK_SHUT;
      out_buzz <= 1'b0;
    end else begin
      st_q     <= st_d;
      tmr_q    <= tmr_d;
      fail_q   <= fail_d;
      out      <= out_d;
      out_buzz <= buzz_d;
    end
  end

endmodule

// File: tb/tb_rsss_lock_ctrl.sv
// Scoreboard bench for rsss_lock_ctrl: directed scenarios then randomized codes and actions.
module tb_rsss_lock_ctrl;

  localparam logic [1:0] S_IDLE = 2'd0, S_CHECK = 2'd1, S_OPEN = 2'd2, S_LOCKOUT = 2'd3;

  typedef struct packed {
    logic [1:0] st;
    logic [1:0] fc;
    logic       o;
    logic       b;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        code_valid = 1'b0;
  logic        relock = 1'b0;
  logic [15:0] code_in = 16'h0;
  logic        code_ready, out, out_buzz;
  logic [1:0]  state, fail_cnt;
`ifdef LOCK_PROG_EN
  logic        prog_valid = 1'b0;
  logic [15:0] prog_code = 16'h0;
`endif

  rsss_lock_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .code_in    (code_in),
    .relock     (relock),
    .out        (out),
    .out_buzz   (out_buzz),
    .state      (state),
    .fail_cnt   (fail_cnt)
`ifdef LOCK_PROG_EN
    ,
    .prog_valid (prog_valid),
    .prog_code  (prog_code)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t exp_q[$];
  int   dur_q[$];

  // Reference model: stored code and consecutive failure count.
  logic [15:0] m_code = 16'h1732;
  int          m_fails = 0;
  logic [15:0] next_prog = 16'hA5A5;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT (t=%0t)", nm, $time);
  endtask

  // ---------------- monitor ----------------
  int   cyc = 0;
  bit   tracking = 0, in_dur = 0;
  int   acc_cyc = 0, dur_start = 0;
  logic [1:0] dur_st = S_IDLE;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    int   d;
    if (!rst) begin
      tracking = 0;
      in_dur   = 0;
    end else begin
      chk("ready_vs_state", code_ready, state == S_IDLE);
      chk("out_buzz_vs_state", {out, out_buzz}, {state != S_OPEN, state == S_LOCKOUT});
      if (in_dur && state != dur_st) begin
        in_dur = 0;
        if (dur_q.size() == 0) begin
          tmo("dwell_expectation_missing");
        end else begin
          d = dur_q.pop_front();
          chk("dwell_cycles", cyc - dur_start, d);
        end
        chk("fail_cnt_after_dwell", fail_cnt, 0);
      end
      if (tracking && state != S_CHECK) begin
        tracking = 0;
        if (exp_q.size() == 0) begin
          tmo("result_expectation_missing");
        end else begin
          e = exp_q.pop_front();
          chk("result_state", state, e.st);
          chk("result_fail_cnt", fail_cnt, e.fc);
          chk("result_out", out, e.o);
          chk("result_buzz", out_buzz, e.b);
          chk("check_latency", cyc - acc_cyc, 16);
        end
        if (state == S_OPEN || state == S_LOCKOUT) begin
          in_dur    = 1;
          dur_st    = state;
          dur_start = cyc;
        end
      end else if (!tracking) begin
        chk("check_without_accept", state == S_CHECK, 0);
      end
      if (code_valid && code_ready) begin
        tracking = 1;
        acc_cyc  = cyc + 1;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic submit(input logic [15:0] c);
    int   t;
    exp_t e;
    t = 0;
    while (!code_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) tmo("code_ready_wait");
    if (c == m_code) begin
      m_fails = 0;
      e.st = S_OPEN; e.fc = 2'd0; e.o = 1'b0; e.b = 1'b0;
    end else begin
      m_fails++;
      if (m_fails == 3) begin
        e.st = S_LOCKOUT; e.fc = 2'd3; e.o = 1'b1; e.b = 1'b1;
        dur_q.push_back(64);
        m_fails = 0;
      end else begin
        e.st = S_IDLE; e.fc = 2'(m_fails); e.o = 1'b1; e.b = 1'b0;
      end
    end
    exp_q.push_back(e);
    code_valid = 1'b1;
    code_in    = c;
    @(posedge clk); #1;
    code_valid = 1'b0;
    code_in    = 16'($urandom);
  endtask

  // act: 0 = let OPEN time out, 1..32 = relock in that OPEN cycle, >32 = reprogram (if enabled)
  task automatic finish_txn(input int act);
    int t, k;
    t = 0;
    do begin
      @(posedge clk); #1;
      relock = 1'b0;
      t++;
      if (state == S_CHECK) relock = ($urandom_range(0, 2) == 0);
    end while (state == S_CHECK && t < 40);
    relock = 1'b0;
    if (t >= 40) tmo("check_end_wait");
    if (state == S_OPEN) begin
      k = (act >= 1 && act <= 32) ? act : 0;
`ifdef LOCK_PROG_EN
      if (act > 32) k = $urandom_range(1, 32);
`endif
      if (k == 0) begin
        dur_q.push_back(32);
        t = 0;
        while (state == S_OPEN && t < 40) begin
          @(posedge clk); #1;
          t++;
        end
        if (t >= 40) tmo("open_timeout_wait");
      end else begin
        dur_q.push_back(k);
        repeat (k - 1) begin
          @(posedge clk); #1;
        end
`ifdef LOCK_PROG_EN
        if (act > 32) begin
          prog_valid = 1'b1;
          prog_code  = next_prog;
          m_code     = next_prog;
        end else begin
          relock = 1'b1;
        end
`else
        relock = 1'b1;
`endif
        @(posedge clk); #1;
        relock = 1'b0;
`ifdef LOCK_PROG_EN
        prog_valid = 1'b0;
`endif
      end
    end else if (state == S_LOCKOUT) begin
      t = 0;
      do begin
        @(posedge clk); #1;
        code_valid = 1'b0;
        relock     = 1'b0;
        t++;
        if (state == S_LOCKOUT) begin
          code_valid = $urandom_range(0, 1) == 1;
          code_in    = ($urandom_range(0, 1) == 1) ? m_code : 16'($urandom);
          relock     = $urandom_range(0, 1) == 1;
        end
      end while (state == S_LOCKOUT && t < 80);
      code_valid = 1'b0;
      relock     = 1'b0;
      if (t >= 80) tmo("lockout_end_wait");
    end
  endtask

  task automatic run_txn(input logic [15:0] c, input int act);
    submit(c);
    finish_txn(act);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] c;
    int          r;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", state, S_IDLE);
    chk("reset_out", out, 1'b1);
    chk("reset_buzz", out_buzz, 1'b0);
    chk("reset_fail_cnt", fail_cnt, 0);
    chk("reset_ready", code_ready, 1'b1);
    rst = 1'b1;

    run_txn(16'h1732, 0);
    run_txn(16'h1733, 0);
    run_txn(16'h1733, 0);
    run_txn(16'h1733, 0);
    chk("post_lockout_ready", code_ready, 1'b1);

    run_txn(16'h1733, 0);
    run_txn(16'hFFFF, 0);
    run_txn(16'h1732, 7);
    run_txn(16'h0000, 0);
    run_txn(16'h1732, 5);
    run_txn(16'h1732, 32);

    // Reset during the 8th CHECK cycle aborts without counting a failure.
    submit(16'h1732);
    repeat (7) begin
      @(posedge clk); #1;
    end
    rst = 1'b0;
    #1;
    chk("abort_state", state, S_IDLE);
    chk("abort_out", out, 1'b1);
    chk("abort_fail_cnt", fail_cnt, 0);
    chk("abort_buzz", out_buzz, 1'b0);
    exp_q.delete();
    m_fails = 0;
    m_code  = 16'h1732;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    run_txn(16'h1732, 0);

`ifdef LOCK_PROG_EN
    next_prog = 16'hA5A5;
    run_txn(16'h1732, 33);
    run_txn(16'h1732, 0);
    run_txn(16'hA5A5, 0);
`endif

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 2);
      if (r == 0)      c = m_code;
      else if (r == 1) c = m_code ^ (16'h1 << $urandom_range(0, 15));
      else             c = 16'($urandom);
      next_prog = 16'($urandom);
      run_txn(c, $urandom_range(0, 40));
    end

    repeat (5) begin
      @(posedge clk); #1;
    end
    chk("pending_results", exp_q.size(), 0);
    chk("pending_dwells", dur_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
